// File: rtl/flash_sample_reader.sv
// rtl/flash_sample_reader.sv - flash word reader that splits words into 16-bit audio samples
//
// Purpose:
//   Reads one 32-bit word from the flash Avalon-MM master port at addr_in.
//   It emits the two 16-bit halves on successive sample ticks, in play-direction order.
//   It then pulses addr_step so the address controller advances one word.
//
// Optional feature (macro FLASH_READER_TIMEOUT_EN):
//   When the macro is defined, WAIT_DATA gives up after TIMEOUT_CYC cycles without readdatavalid.
//   The word is then forced to 0 and timeout_err is set; it stays set until rst.
//   When the macro is undefined, timeout_err is a constant 0.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   playpause, dir           1 = play / 0 = pause; 1 = forward / 0 = reverse
//   sample_tick              single-cycle audio-rate strobe
//   addr_in                  current word address from the address controller
//   addr_step                single-cycle advance request to the address controller
//   flash_mem_*              Avalon-MM read master (read, address, byteenable, waitrequest,
//                            readdata, readdatavalid)
//   sample_out, sample_valid current sample and its single-cycle update strobe
//   timeout_err              sticky read-timeout flag
module flash_sample_reader #(
  parameter int ADDR_W      = 23,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              playpause,
  input  logic              dir,
  input  logic              sample_tick,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              addr_step,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    REQ       = 3'd2,
    WAIT_DATA = 3'd3,
    TICK0     = 3'd4,
    TICK1     = 3'd5,
    STEP      = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic                read_q, read_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                step_q, step_d;
  logic [15:0]         sample_q, sample_d;
  logic                valid_q, valid_d;
  logic [31:0]         word_q, word_d;
  logic                ord_q, ord_d;

`ifdef FLASH_READER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                terr_q, terr_d;
`endif

  // A tick is only honoured while playing; in pause the FSM parks in TICK0/TICK1.
  logic tick_ok;
  assign tick_ok = sample_tick & playpause;

  always_comb begin
    state_d  = state_q;
    read_d   = read_q;
    addr_d   = addr_q;
    step_d   = 1'b0;
    sample_d = sample_q;
    valid_d  = 1'b0;
    word_d   = word_q;
    ord_d    = ord_q;
`ifdef FLASH_READER_TIMEOUT_EN
    cnt_d    = cnt_q;
    terr_d   = terr_q;
`endif
    case (state_q)
      IDLE: begin
        if (playpause) state_d = LOAD;
      end
      LOAD: begin
        addr_d  = addr_in;
        read_d  = 1'b1;
        state_d = REQ;
      end
      REQ: begin
        // The read is accepted on the edge where waitrequest is low.
        // The bus transaction completes even if playback is paused meanwhile.
        if (!flash_mem_waitrequest) begin
          read_d  = 1'b0;
          state_d = WAIT_DATA;
`ifdef FLASH_READER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          word_d  = flash_mem_readdata;
          ord_d   = dir;
          state_d = TICK0;
        end
`ifdef FLASH_READER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          word_d  = 32'd0;
          ord_d   = dir;
          terr_d  = 1'b1;
          state_d = TICK0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      TICK0: begin
        if (tick_ok) begin
          sample_d = ord_q ? word_q[15:0] : word_q[31:16];
          valid_d  = 1'b1;
          state_d  = TICK1;
        end
      end
      TICK1: begin
        if (tick_ok) begin
          sample_d = ord_q ? word_q[31:16] : word_q[15:0];
          valid_d  = 1'b1;
          // Registered, so addr_step is high during exactly the STEP cycle.
          step_d   = 1'b1;
          state_d  = STEP;
        end
      end
      STEP: begin
        state_d = playpause ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      read_q   <= 1'b0;
      addr_q   <= '0;
      step_q   <= 1'b0;
      sample_q <= 16'd0;
      valid_q  <= 1'b0;
      word_q   <= 32'd0;
      ord_q    <= 1'b0;
`ifdef FLASH_READER_TIMEOUT_EN
      cnt_q    <= '0;
      terr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      step_q   <= step_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      word_q   <= word_d;
      ord_q    <= ord_d;
`ifdef FLASH_READER_TIMEOUT_EN
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
`endif
    end
  end

  assign flash_mem_read       = read_q;
  assign flash_mem_address    = addr_q;
  assign flash_mem_byteenable = 4'b1111;
  assign addr_step            = step_q;
  assign sample_out           = sample_q;
  assign sample_valid         = valid_q;
`ifdef FLASH_READER_TIMEOUT_EN
  assign timeout_err          = terr_q;
`else
  assign timeout_err          = 1'b0;
`endif

endmodule

// File: tb/tb_flash_sample_reader.sv
// tb/tb_flash_sample_reader.sv - self-checking bench for flash_sample_reader
module tb_flash_sample_reader;

  localparam int ADDR_W = 23;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              playpause = 1'b0;
  logic              dir = 1'b1;
  logic              sample_tick = 1'b0;
  logic [ADDR_W-1:0] addr_in = '0;
  logic              addr_step;
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic              flash_mem_waitrequest = 1'b1;
  logic [31:0]       flash_mem_readdata = 32'd0;
  logic              flash_mem_readdatavalid = 1'b0;
  logic [15:0]       sample_out;
  logic              sample_valid;
  logic              timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flash_sample_reader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(8)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .playpause               (playpause),
    .dir                     (dir),
    .sample_tick             (sample_tick),
    .addr_in                 (addr_in),
    .addr_step               (addr_step),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .sample_out              (sample_out),
    .sample_valid            (sample_valid),
    .timeout_err             (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: the samples owed to the audio path are held in a queue.
  // A delivered word pushes two samples in the order set by dir at that moment.
  // Each honoured tick pops one sample, and popping the last one must come with addr_step.
  logic [15:0] exp_q[$];
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic        exp_valid = 1'b0;
  logic [15:0] exp_sample = 16'd0;
  logic        exp_step = 1'b0;
  logic        exp_terr = 1'b0;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    exp_valid = 1'b0;
    exp_step  = 1'b0;
    if (rst) begin
      exp_q.delete();
      pend       = 1'b0;
      exp_sample = 16'd0;
      exp_terr   = 1'b0;
    end else begin
      if (sample_tick && playpause && exp_q.size() > 0) begin
        exp_sample = exp_q.pop_front();
        exp_valid  = 1'b1;
        exp_step   = (exp_q.size() == 0);
      end
      if (pend) begin
        if (flash_mem_readdatavalid) begin
          pend = 1'b0;
          if (dir) begin
            exp_q.push_back(flash_mem_readdata[15:0]);
            exp_q.push_back(flash_mem_readdata[31:16]);
          end else begin
            exp_q.push_back(flash_mem_readdata[31:16]);
            exp_q.push_back(flash_mem_readdata[15:0]);
          end
        end else begin
          pend_cnt++;
`ifdef FLASH_READER_TIMEOUT_EN
          if (pend_cnt == 8) begin
            pend = 1'b0;
            exp_terr = 1'b1;
            exp_q.push_back(16'd0);
            exp_q.push_back(16'd0);
          end
`endif
        end
      end
      if (flash_mem_read && !flash_mem_waitrequest) begin
        pend     = 1'b1;
        pend_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_sample_valid", {31'd0, sample_valid}, {31'd0, exp_valid});
      check("cyc_sample_out", {16'd0, sample_out}, {16'd0, exp_sample});
      check("cyc_addr_step", {31'd0, addr_step}, {31'd0, exp_step});
      check("cyc_timeout_err", {31'd0, timeout_err}, {31'd0, exp_terr});
      check("cyc_byteenable", {28'd0, flash_mem_byteenable}, 32'hF);
    end
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_expect(input string name, input logic [15:0] s, input logic st);
    sample_tick = 1'b1;
    step_clk();
    sample_tick = 1'b0;
    check({name, "_valid"}, {31'd0, sample_valid}, 32'd1);
    check({name, "_sample"}, {16'd0, sample_out}, {16'd0, s});
    check({name, "_step"}, {31'd0, addr_step}, {31'd0, st});
  endtask

  // Waits for a read request, stalls it, then accepts it.
  // A dropped tick can optionally be injected during the stall.
  task automatic serve_req(input logic [31:0] exp_addr, input int stall, input bit tick_in_stall);
    int n = 0;
    while (!flash_mem_read && n < 50) begin
      step_clk();
      n++;
    end
    if (!flash_mem_read) begin
      check("read_request_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      check("addr_during_stall", {9'd0, flash_mem_address}, exp_addr);
      sample_tick = tick_in_stall && (i == 0);
      step_clk();
      sample_tick = 1'b0;
    end
    check("addr_at_accept", {9'd0, flash_mem_address}, exp_addr);
    check("read_at_accept", {31'd0, flash_mem_read}, 32'd1);
    flash_mem_waitrequest = 1'b0;
    step_clk();
    flash_mem_waitrequest = 1'b1;
  endtask

  task automatic give_data(input logic [31:0] word, input bit tick_same);
    sample_tick = 1'b1;  // lands in WAIT_DATA and must be dropped
    step_clk();
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata = word;
    sample_tick = tick_same;
    step_clk();
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata = 32'd0;
    sample_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) step_clk();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_read", {31'd0, flash_mem_read}, 32'd0);
    check("reset_addr", {9'd0, flash_mem_address}, 32'd0);
    check("reset_sample", {16'd0, sample_out}, 32'd0);
    repeat (3) step_clk();
    check("idle_no_read", {31'd0, flash_mem_read}, 32'd0);

    // Forward play
    playpause = 1'b1;
    dir = 1'b1;
    addr_in = 23'h000010;
    serve_req(32'h10, 2, 1'b1);
    give_data(32'hAAAA5555, 1'b0);
    tick_expect("fwd0", 16'h5555, 1'b0);
    tick_expect("fwd1", 16'hAAAA, 1'b1);
    addr_in = 23'h000011;

    // Reverse play, next address
    dir = 1'b0;
    serve_req(32'h11, 0, 1'b0);
    give_data(32'h12348000, 1'b0);
    tick_expect("rev0", 16'h1234, 1'b0);
    tick_expect("rev1", 16'h8000, 1'b1);
    addr_in = 23'h000012;

    // Pause in TICK1
    dir = 1'b1;
    serve_req(32'h12, 1, 1'b0);
    give_data(32'h00050006, 1'b0);
    tick_expect("pause0", 16'h0006, 1'b0);
    playpause = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample_tick = 1'b1;
      step_clk();
      sample_tick = 1'b0;
      check("paused_no_valid", {31'd0, sample_valid}, 32'd0);
      step_clk();
    end
    check("paused_hold", {16'd0, sample_out}, 32'h0006);
    playpause = 1'b1;
    tick_expect("resume1", 16'h0005, 1'b1);
    addr_in = 23'h000013;

    // Reset in WAIT_DATA, then a stale readdatavalid
    serve_req(32'h13, 0, 1'b0);
    step_clk();
    rst = 1'b1;
    playpause = 1'b0;
    step_clk();
    rst = 1'b0;
    check("rst_read", {31'd0, flash_mem_read}, 32'd0);
    check("rst_sample", {16'd0, sample_out}, 32'd0);
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata = 32'hFFFFFFFF;
    step_clk();
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata = 32'd0;
    for (int i = 0; i < 3; i++) begin
      sample_tick = 1'b1;
      step_clk();
      sample_tick = 1'b0;
      check("stale_no_valid", {31'd0, sample_valid}, 32'd0);
      check("stale_sample", {16'd0, sample_out}, 32'd0);
      check("stale_read", {31'd0, flash_mem_read}, 32'd0);
    end

    // Dir change mid-word; a tick arriving with readdatavalid is not consumed
    playpause = 1'b1;
    dir = 1'b1;
    addr_in = 23'h000020;
    serve_req(32'h20, 0, 1'b0);
    give_data(32'hBEEFCAFE, 1'b1);
    step_clk();
    check("simul_tick_dropped", {16'd0, sample_out}, 32'd0);
    tick_expect("dchg0", 16'hCAFE, 1'b0);
    dir = 1'b0;
    tick_expect("dchg1", 16'hBEEF, 1'b1);
    addr_in = 23'h000021;
    serve_req(32'h21, 0, 1'b0);
    give_data(32'h11112222, 1'b0);
    tick_expect("dnext0", 16'h1111, 1'b0);
    tick_expect("dnext1", 16'h2222, 1'b1);

`ifdef FLASH_READER_TIMEOUT_EN
    addr_in = 23'h000030;
    serve_req(32'h30, 0, 1'b0);
    begin
      int n = 0;
      while (!timeout_err && n < 20) begin
        step_clk();
        n++;
      end
      check("timeout_cycles", n, 32'd8);
    end
    tick_expect("to0", 16'h0000, 1'b0);
    tick_expect("to1", 16'h0000, 1'b1);
`endif
    playpause = 1'b0;
    repeat (4) step_clk();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_sample_reader.md
Name: flash_sample_reader

Overview:
Consumer end of the flash address path: takes the current word address from the address controller and issues a read on the flash Avalon-MM master port. It splits each 32-bit word into two 16-bit audio samples, emits them on successive sample ticks in play-direction order, then pulses a step request back to the address controller. It sits between the address controller, the flash controller and the audio output path.

Parameters:
ADDR_W, 23, flash word-address width
TIMEOUT_CYC, 255, cycles allowed in WAIT_DATA before timeout (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
playpause  in  1  1 = play, 0 = pause
dir  in  1  1 = forward, 0 = reverse
sample_tick  in  1  single-cycle audio-rate strobe, synchronous to clk
addr_in  in  ADDR_W  current word address from the address controller
addr_step  out  1  single-cycle request for the address controller to advance one word
flash_mem_read  out  1  Avalon read request
flash_mem_address  out  ADDR_W  Avalon word address
flash_mem_byteenable  out  4  always 4'b1111
flash_mem_waitrequest  in  1  Avalon stall
flash_mem_readdata  in  32  Avalon read data
flash_mem_readdatavalid  in  1  Avalon read data valid
sample_out  out  16  current audio sample, two's complement
sample_valid  out  1  single-cycle pulse when sample_out updates
timeout_err  out  1  sticky timeout flag; constant 0 when the feature is compiled out

Behaviour:
- Reset values: state=IDLE, flash_mem_read=0, flash_mem_address=0, addr_step=0, sample_out=0, sample_valid=0, timeout_err=0, latched word=0.
- All outputs are registered. flash_mem_byteenable is the constant 4'b1111.
- FSM states: IDLE, LOAD, REQ, WAIT_DATA, TICK0, TICK1, STEP.
- IDLE: if playpause=1, go to LOAD next cycle. Otherwise stay in IDLE.
- LOAD: flash_mem_address <= addr_in, flash_mem_read <= 1, go to REQ.
- REQ: hold flash_mem_read and flash_mem_address stable while waitrequest=1. When waitrequest=0, the read is accepted on that edge: flash_mem_read <= 0, go to WAIT_DATA.
- WAIT_DATA: on readdatavalid=1, latch readdata and latch dir into ord, then go to TICK0.
- Ordering:
  - ord=1 (forward): first sample = word[15:0], second = word[31:16].
  - ord=0 (reverse): first sample = word[31:16], second = word[15:0].
  - ord is fixed for the whole word; a dir change takes effect at the next word.
- TICK0: on sample_tick=1 with playpause=1, sample_out <= first sample, sample_valid=1 the next cycle, go to TICK1.
- TICK1: same rule as TICK0 with the second sample; go to STEP.
- STEP: addr_step=1 for exactly this cycle; the address controller updates at the end of this cycle. Go to LOAD if playpause=1, else IDLE.
- Latency:
  - sample_tick to sample_valid/sample_out: 1 cycle.
  - Minimum cycles from STEP to the new flash_mem_read: 1 (LOAD).
- Pause:
  - sample_tick is ignored while playpause=0. The FSM holds in TICK0/TICK1 and sample_out holds its value.
  - An in-flight bus transaction (REQ/WAIT_DATA) always completes regardless of playpause.
- readdatavalid outside WAIT_DATA is ignored.
- Simultaneous events:
  - A tick arriving in the same cycle as readdatavalid is not consumed. The first sample goes out on the next tick.
  - Ticks arriving in REQ, WAIT_DATA, LOAD or STEP are dropped, not queued.
- Reset mid-operation: returns to IDLE on the next edge, drops flash_mem_read immediately, clears all registers.
- Wrap-around of addr_in is the address controller's responsibility; this block forwards addr_in unmodified.

Optional Feature:
- Macro FLASH_READER_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT_DATA.
  - If TIMEOUT_CYC cycles pass with no readdatavalid, the latched word is forced to 0, timeout_err is set (sticky until rst), and the FSM enters TICK0 as if data had arrived.
  - The counter clears on entry to WAIT_DATA.
- When undefined: no counter, WAIT_DATA waits indefinitely, timeout_err is tied to 0.

Test Plan:
- Forward play: rst then playpause=1, dir=1, addr_in=0x000010, waitrequest low after 2 cycles, readdata=0xAAAA5555.
  - Expect flash_mem_address=0x000010 held through the stall.
  - Expect sample_out=0x5555 then 0xAAAA on successive ticks, then a single addr_step pulse.
- Reverse play: dir=0, readdata=0x12348000 -> sample_out=0x1234 then 0x8000; addr_step=1 for one cycle; the next read uses the updated addr_in.
- Pause: playpause=0 while in TICK1, 5 ticks -> no sample_valid, sample_out holds. Then playpause=1, one tick -> second sample emitted and addr_step pulses.
- Reset mid-read: assert rst in WAIT_DATA, then a stale readdatavalid with 0xFFFFFFFF -> IDLE, flash_mem_read=0, sample_out=0, no sample_valid.
- Dir change mid-word: dir 1->0 between TICK0 and TICK1 with word 0xBEEFCAFE -> outputs 0xCAFE then 0xBEEF; the next word uses reverse order.
- With FLASH_READER_TIMEOUT_EN, TIMEOUT_CYC=8: withhold readdatavalid -> after 8 cycles timeout_err=1, the next two ticks output 0x0000 and 0x0000, then addr_step=1.
